// File: rtl/raster_mem_sched_pkg.sv
// Shared types and helpers for the rasterizer memory-unit scheduler.
package raster_mem_sched_pkg;

    localparam int unsigned RASTER_DIM_BITS  = 16;
    localparam int unsigned RASTER_PID_BITS  = 16;
    localparam int unsigned RASTER_DATA_BITS = 32;

    typedef struct packed {
        logic [RASTER_DIM_BITS-1:0]             xloc;
        logic [RASTER_DIM_BITS-1:0]             yloc;
        logic [RASTER_PID_BITS-1:0]             pid;
        logic [2:0][2:0][RASTER_DATA_BITS-1:0]  edges;
    } raster_prim_t;

    typedef enum logic [1:0] {
        RASTER_SCHED_STATE_IDLE   = 2'd0,
        RASTER_SCHED_STATE_LAUNCH = 2'd1,
        RASTER_SCHED_STATE_RUN    = 2'd2,
        RASTER_SCHED_STATE_DONE   = 2'd3
    } raster_sched_state_e;

    function automatic int unsigned raster_idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_mem_sched_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after rr_ptr wins.
module raster_rr_arbiter
    import raster_mem_sched_pkg::*;
#(
    parameter int unsigned NUM_INSTANCES = 2,
    parameter int unsigned IDX_BITS      = raster_idx_bits(NUM_INSTANCES)
) (
    input  logic [NUM_INSTANCES-1:0] valid,
    input  logic                     enable,
    input  logic [IDX_BITS-1:0]      rr_ptr,
    output logic [NUM_INSTANCES-1:0] grant,
    output logic [IDX_BITS-1:0]      grant_idx,
    output logic                     grant_valid
);

    int unsigned         j;
    logic [IDX_BITS-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        cand        = '0;
        if (enable) begin
            for (int unsigned i = 0; i < NUM_INSTANCES; i++) begin
                j = int'(rr_ptr) + i;
                if (j >= NUM_INSTANCES) j = j - NUM_INSTANCES;
                cand = IDX_BITS'(j);
                if (!grant_valid && valid[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/raster_mem_sched.sv
// Launch/completion controller and round-robin output merger for the
// rasterizer memory units.
module raster_mem_sched
    import raster_mem_sched_pkg::*;
#(
    parameter int unsigned NUM_INSTANCES = 2,
    parameter int unsigned PID_BITS      = 16,
    parameter int unsigned DIM_BITS      = 16,
    parameter int unsigned DATA_BITS     = 32,
    parameter int unsigned QUIET_CYCLES  = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_INSTANCES-1:0]               unit_start,
    input  logic [NUM_INSTANCES-1:0]               unit_busy,
    input  logic [NUM_INSTANCES-1:0]               unit_valid,
    input  logic [NUM_INSTANCES*PID_BITS-1:0]      unit_pid,
    input  logic [NUM_INSTANCES*DIM_BITS-1:0]      unit_xloc,
    input  logic [NUM_INSTANCES*DIM_BITS-1:0]      unit_yloc,
    input  logic [NUM_INSTANCES*9*DATA_BITS-1:0]   unit_edges,
    output logic [NUM_INSTANCES-1:0]               unit_ready,
    output logic                                   valid_out,
    output logic [PID_BITS-1:0]                    pid_out,
    output logic [DIM_BITS-1:0]                    xloc_out,
    output logic [DIM_BITS-1:0]                    yloc_out,
    output logic [9*DATA_BITS-1:0]                 edges_out,
    output logic [raster_idx_bits(NUM_INSTANCES)-1:0] src_out,
    input  logic                                   ready_out,
    output logic [31:0]                            prim_count
);

    localparam int unsigned IDX_BITS  = raster_idx_bits(NUM_INSTANCES);
    localparam int unsigned EDGE_BITS = 9 * DATA_BITS;
    localparam int unsigned QCNT_BITS = $clog2(QUIET_CYCLES + 1);

    raster_sched_state_e   state, state_nxt;
    logic [QCNT_BITS-1:0]  quiet_cnt, quiet_cnt_nxt;
    logic [IDX_BITS-1:0]   rr_ptr, grant_idx;
    logic [NUM_INSTANCES-1:0] grant;
    logic                  grant_valid, arb_enable, out_fire, quiet;

    assign out_fire   = valid_out && ready_out;
    // No grants during reset: the held word is discarded, so a handshake would lose the item.
    assign arb_enable = !reset && (!valid_out || ready_out);
    assign quiet      = (unit_busy == '0) && (unit_valid == '0) && !valid_out;

    raster_rr_arbiter #(
        .NUM_INSTANCES (NUM_INSTANCES),
        .IDX_BITS      (IDX_BITS)
    ) u_arb (
        .valid       (unit_valid),
        .enable      (arb_enable),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        unit_ready = grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RASTER_SCHED_STATE_IDLE;
            quiet_cnt <= '0;
        end else begin
            state     <= state_nxt;
            quiet_cnt <= quiet_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        quiet_cnt_nxt = '0;
        busy          = 1'b1;
        done          = 1'b0;
        unit_start    = '0;
        case (state)
            RASTER_SCHED_STATE_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RASTER_SCHED_STATE_LAUNCH;
            end
            RASTER_SCHED_STATE_LAUNCH: begin
                unit_start = '1;
                state_nxt  = RASTER_SCHED_STATE_RUN;
            end
            RASTER_SCHED_STATE_RUN: begin
                if (quiet) begin
                    quiet_cnt_nxt = quiet_cnt + 1'b1;
                    if (quiet_cnt_nxt == QCNT_BITS'(QUIET_CYCLES))
                        state_nxt = RASTER_SCHED_STATE_DONE;
                end
            end
            RASTER_SCHED_STATE_DONE: begin
                done      = 1'b1;
                state_nxt = RASTER_SCHED_STATE_IDLE;
            end
            default: state_nxt = RASTER_SCHED_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            rr_ptr    <= '0;
        end else if (grant_valid) begin
            valid_out <= 1'b1;
            rr_ptr    <= (grant_idx == IDX_BITS'(NUM_INSTANCES - 1)) ? '0 : grant_idx + 1'b1;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_valid) begin
            pid_out   <= unit_pid[grant_idx*PID_BITS +: PID_BITS];
            xloc_out  <= unit_xloc[grant_idx*DIM_BITS +: DIM_BITS];
            yloc_out  <= unit_yloc[grant_idx*DIM_BITS +: DIM_BITS];
            edges_out <= unit_edges[grant_idx*EDGE_BITS +: EDGE_BITS];
            src_out   <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            prim_count <= '0;
        else if (state == RASTER_SCHED_STATE_IDLE && start)
            prim_count <= '0;
        else if (out_fire)
            prim_count <= prim_count + 32'd1;
    end

endmodule

// File: tb/tb_raster_mem_sched.sv
// Directed self-checking bench for raster_mem_sched with two behavioural units.
module tb_raster_mem_sched;

    localparam int N  = 2;
    localparam int PB = 16;
    localparam int DB = 16;
    localparam int XB = 32;
    localparam int Q  = 2;

    logic            clk = 1'b0;
    logic            reset, start, busy, done, valid_out, ready_out;
    logic [N-1:0]    unit_start, unit_busy, unit_valid, unit_ready;
    logic [N*PB-1:0] unit_pid;
    logic [N*DB-1:0] unit_xloc, unit_yloc;
    logic [N*9*XB-1:0] unit_edges;
    logic [PB-1:0]   pid_out;
    logic [DB-1:0]   xloc_out, yloc_out;
    logic [9*XB-1:0] edges_out;
    logic [0:0]      src_out;
    logic [31:0]     prim_count;

    raster_mem_sched #(
        .NUM_INSTANCES (N),
        .PID_BITS      (PB),
        .DIM_BITS      (DB),
        .DATA_BITS     (XB),
        .QUIET_CYCLES  (Q)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .unit_start (unit_start),
        .unit_busy  (unit_busy),
        .unit_valid (unit_valid),
        .unit_pid   (unit_pid),
        .unit_xloc  (unit_xloc),
        .unit_yloc  (unit_yloc),
        .unit_edges (unit_edges),
        .unit_ready (unit_ready),
        .valid_out  (valid_out),
        .pid_out    (pid_out),
        .xloc_out   (xloc_out),
        .yloc_out   (yloc_out),
        .edges_out  (edges_out),
        .src_out    (src_out),
        .ready_out  (ready_out),
        .prim_count (prim_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit model_en;
    bit active [N];
    int left   [N];
    int sent   [N];
    int done_cnt, ustart_cnt, k;
    int log_src[$];
    int log_pid[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_units();
        if (model_en) begin
            for (int u = 0; u < N; u++) begin
                unit_valid[u] = active[u] && (left[u] > 0);
                unit_busy[u]  = unit_valid[u];
                unit_pid[u*PB +: PB]    = 16'(u*256 + sent[u] + 16);
                unit_xloc[u*DB +: DB]   = 16'(u*256 + sent[u] + 16 + 'h1000);
                unit_yloc[u*DB +: DB]   = 16'(u*256 + sent[u] + 16 + 'h2000);
                unit_edges[u*9*XB +: 9*XB] = {9{32'(u*256 + sent[u] + 16)}};
            end
        end
    endtask

    // Observe the current cycle, advance one clock, then update unit models.
    task automatic tick();
        logic [N-1:0] hs;
        hs = unit_valid & unit_ready;
        if (valid_out && ready_out) begin
            log_src.push_back(int'(src_out));
            log_pid.push_back(int'(pid_out));
        end
        if (done) done_cnt++;
        if (unit_start != '0) begin
            ustart_cnt++;
            for (int u = 0; u < N; u++) active[u] = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int u = 0; u < N; u++) begin
            if (hs[u]) begin
                left[u]--;
                sent[u]++;
            end
        end
        drive_units();
        #1;
    endtask

    task automatic new_frame(input int l0, input int l1);
        left[0] = l0; left[1] = l1;
        sent[0] = 0;  sent[1] = 0;
        active[0] = 1'b0; active[1] = 1'b0;
        done_cnt = 0; ustart_cnt = 0;
        log_src.delete(); log_pid.delete();
        drive_units();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ready_out = 1'b1;
        unit_busy = '0; unit_valid = '0; unit_pid = '0;
        unit_xloc = '0; unit_yloc = '0; unit_edges = '0;
        model_en = 1'b1;
        new_frame(0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_unit_start", unit_start, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_prim_count", prim_count, 0);
        reset = 1'b0;
        tick();

        // Frame 1: both units emit three items concurrently.
        new_frame(3, 3);
        start = 1'b1; #1;
        tick();
        check("t1_launch_unit_start", unit_start, 2'b11);
        for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
        repeat (3) tick();
        check("t1_done_pulses", done_cnt, 1);
        check("t1_start_pulses", ustart_cnt, 1);
        check("t1_prim_count", prim_count, 6);
        check("t1_busy_idle", busy, 0);
        check("t1_fires", log_src.size(), 6);
        for (int i = 0; i < 6 && i < log_src.size(); i++) begin
            check($sformatf("t1_src%0d", i), log_src[i], i % 2);
            check($sformatf("t1_pid%0d", i), log_pid[i], (i % 2) * 256 + i / 2 + 16);
        end

        // Frame 2: zero tiles, done 1+Q+1 cycles after start.
        new_frame(0, 0);
        start = 1'b1; #1;
        tick();
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("t2_done_latency", k, 1 + Q + 1);
        check("t2_prim_count", prim_count, 0);
        check("t2_busy_in_done", busy, 1);
        tick();

        // Frame 3: backpressure then drain.
        new_frame(2, 2);
        ready_out = 1'b0;
        start = 1'b1; #1;
        tick(); tick(); tick();
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", valid_out, 1);
            check("t3_hold_pid", pid_out, 16'h0010);
            check("t3_hold_src", src_out, 0);
            check("t3_hold_xloc", xloc_out, 16'h1010);
            check("t3_hold_yloc", yloc_out, 16'h2010);
            check("t3_hold_edge0", edges_out[31:0], 32'h10);
            check("t3_hold_edge8", edges_out[287:256], 32'h10);
            check("t3_hold_ready", unit_ready, 0);
            tick();
        end
        ready_out = 1'b1; #1;
        for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
        check("t3_done_pulses", done_cnt, 1);
        check("t3_prim_count", prim_count, 4);
        check("t3_fires", log_src.size(), 4);
        for (int i = 0; i < 4 && i < log_src.size(); i++) begin
            check($sformatf("t3_src%0d", i), log_src[i], i % 2);
            check($sformatf("t3_pid%0d", i), log_pid[i], (i % 2) * 256 + i / 2 + 16);
        end
        tick();

        // Frame 4: unit1 drops busy, valid appears one cycle later.
        new_frame(0, 0);
        model_en = 1'b0;
        start = 1'b1; #1;
        tick(); tick();
        unit_busy = 2'b10; #1;
        tick();
        unit_busy = 2'b00; #1;
        tick();
        unit_valid = 2'b10;
        unit_pid[31:16] = 16'h0055;
        #1;
        check("t4_no_done_r3", done, 0);
        check("t4_grant", unit_ready, 2'b10);
        tick();
        unit_valid = 2'b00; #1;
        check("t4_out_valid", valid_out, 1);
        check("t4_out_src", src_out, 1);
        check("t4_out_pid", pid_out, 16'h0055);
        check("t4_no_done_r4", done, 0);
        tick();
        check("t4_no_done_r5", done, 0);
        check("t4_out_drained", valid_out, 0);
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("t4_done_after_fire", k, Q);
        check("t4_prim_count", prim_count, 1);
        check("t4_early_done", done_cnt, 0);
        tick();
        model_en = 1'b1;

        // Frame 5: start during RUN is ignored.
        new_frame(0, 0);
        start = 1'b1; #1;
        tick(); tick();
        start = 1'b1; #1;
        tick();
        for (int c = 0; c < 20 && done_cnt == 0; c++) tick();
        repeat (4) tick();
        check("t5_start_pulses", ustart_cnt, 1);
        check("t5_done_pulses", done_cnt, 1);
        check("t5_not_requeued", busy, 0);

        // Frame 6: reset mid-RUN with a held output word.
        new_frame(1, 0);
        ready_out = 1'b0;
        start = 1'b1; #1;
        tick(); tick(); tick();
        check("t6_pre_valid", valid_out, 1);
        check("t6_pre_busy", busy, 1);
        reset = 1'b1; #1;
        tick();
        check("t6_rst_valid", valid_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", unit_ready, 0);
        check("t6_rst_prim_count", prim_count, 0);
        reset = 1'b0;
        ready_out = 1'b1;
        new_frame(0, 0);
        start = 1'b1; #1;
        tick();
        check("t6_relaunch", unit_start, 2'b11);
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("t6_done_latency", k, 1 + Q + 1);
        repeat (2) tick();
        check("t6_done_pulses", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
